uart_status_tx: RTL and testbench



---
 rtl/uart_status_tx.sv | 158 +++++++++++++++
 tb/tb_uart_status_tx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_status_tx.sv
// rtl/uart_status_tx.sv - UART 8N1 transmitter for a 9-byte CPU status frame (header, PC, opcode, ACC, MR, flags, checksum)
module uart_status_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  FRAME_HEADER = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [7:0]  i_pc,
    input  logic [7:0]  i_opcode,
    input  logic [15:0] i_acc,
    input  logic [15:0] i_mr,
    input  logic [4:0]  i_flags,
    output logic        o_tx,
    output logic        o_busy,
    output logic        o_done
);

    localparam int             CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam int             NBYTES   = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [3:0]      byte_idx_q, byte_idx_d;
    logic            tx_q, tx_d;
    logic [7:0]      frame_buf [0:NBYTES-1];
    logic            accept;
    logic            bit_end;
    logic [7:0]      checksum;

    assign accept   = (state_q == IDLE) && i_start;
    assign bit_end  = (clk_cnt_q == CNT_LAST);
    assign checksum = i_pc ^ i_opcode ^ i_acc[15:8] ^ i_acc[7:0]
                    ^ i_mr[15:8] ^ i_mr[7:0] ^ {3'b000, i_flags};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            tx_q       <= tx_d;
        end
    end

    // Snapshot is taken once per accepted start; inputs are free to move afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NBYTES; i++) begin
                frame_buf[i] <= 8'h00;
            end
        end else if (accept) begin
            frame_buf[0] <= FRAME_HEADER;
            frame_buf[1] <= i_pc;
            frame_buf[2] <= i_opcode;
            frame_buf[3] <= i_acc[15:8];
            frame_buf[4] <= i_acc[7:0];
            frame_buf[5] <= i_mr[15:8];
            frame_buf[6] <= i_mr[7:0];
            frame_buf[7] <= {3'b000, i_flags};
            frame_buf[8] <= checksum;
        end
    end

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d    = START;
                    clk_cnt_d  = '0;
                    bit_idx_d  = '0;
                    byte_idx_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    if (byte_idx_q < 4'd8) begin
                        byte_idx_d = byte_idx_q + 1'b1;
                        state_d    = START;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The line level is decoded from the next state so the registered o_tx lines up with the FSM.
    always_comb begin
        tx_d   = 1'b1;
        o_busy = 1'b0;
        o_done = 1'b0;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = frame_buf[byte_idx_d][bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        case (state_q)
            START, DATA, STOP: o_busy = 1'b1;
            DONE:              o_done = 1'b1;
            default:           ;
        endcase
    end

    assign o_tx = tx_q;

endmodule

// File: tb/tb_uart_status_tx.sv
// tb/tb_uart_status_tx.sv - self-checking bench for uart_status_tx against a frame-level UART model
module tb_uart_status_tx;

    localparam int CPB  = 4;
    localparam int SCPB = 868;

    logic        clk = 1'b0;
    logic        rst_n, start;
    logic [7:0]  pc, op;
    logic [15:0] acc, mr;
    logic [4:0]  flags;
    logic        tx, busy, done;

    logic        s_rst_n, s_start;
    logic [7:0]  s_pc, s_op;
    logic [15:0] s_acc, s_mr;
    logic [4:0]  s_flags;
    logic        s_tx, s_busy, s_done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_f [9];
    logic [7:0] exp_s [9];

    always #5 clk = ~clk;

    uart_status_tx #(.CLKS_PER_BIT(CPB)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pc(pc), .i_opcode(op),
        .i_acc(acc), .i_mr(mr), .i_flags(flags), .o_tx(tx), .o_busy(busy), .o_done(done)
    );

    uart_status_tx dut_slow (
        .i_clk(clk), .i_rst_n(s_rst_n), .i_start(s_start), .i_pc(s_pc), .i_opcode(s_op),
        .i_acc(s_acc), .i_mr(s_mr), .i_flags(s_flags), .o_tx(s_tx), .o_busy(s_busy), .o_done(s_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic build_frame(input logic [7:0] p, input logic [7:0] o, input logic [15:0] a,
                               input logic [15:0] m, input logic [4:0] f, output logic [7:0] b [9]);
        b[0] = 8'hA5;
        b[1] = p;
        b[2] = o;
        b[3] = a[15:8];
        b[4] = a[7:0];
        b[5] = m[15:8];
        b[6] = m[7:0];
        b[7] = {3'b000, f};
        b[8] = 8'h00;
        for (int i = 1; i <= 7; i++) b[8] = b[8] ^ b[i];
    endtask

    function automatic logic line_bit(input logic [7:0] byt, input int pos);
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return byt[pos-1];
    endfunction

    // mode 0: plain frame, 1: disturb inputs and pulse start mid-frame, 2: hold start high throughout
    task automatic run_frame(input int mode, input string tag);
        logic [7:0] dec [9];
        bit busy_ok, done_ok, framing_ok, seen;
        int j, p;
        busy_ok = 1; done_ok = 1; framing_ok = 1;
        for (int i = 0; i < 9; i++) dec[i] = 8'h00;
        build_frame(pc, op, acc, mr, flags, exp_f);
        @(negedge clk); start = 1'b1;
        @(negedge clk); if (mode != 2) start = 1'b0;
        for (int k = 0; k <= 90*CPB; k++) begin
            if (k < 90*CPB) begin
                if (busy !== 1'b1) busy_ok = 0;
                if (done !== 1'b0) done_ok = 0;
                if (k % CPB == CPB/2) begin
                    j = k / CPB;
                    p = j % 10;
                    if (p >= 1 && p <= 8) dec[j/10][p-1] = tx;
                    else if (tx !== line_bit(8'h00, p)) framing_ok = 0;
                end
                if (mode == 1 && k == 32*CPB) begin
                    pc = 0; op = 0; acc = 0; mr = 0; flags = 0; start = 1'b1;
                end
                if (mode == 1 && k == 32*CPB + 1) start = 1'b0;
                @(negedge clk);
            end else begin
                check({tag, ".done_at_latency"}, {31'd0, done}, 32'd1);
                check({tag, ".busy_in_done"}, {31'd0, busy}, 32'd0);
                check({tag, ".tx_in_done"}, {31'd0, tx}, 32'd1);
            end
        end
        check({tag, ".busy_window"}, {31'd0, busy_ok}, 32'd1);
        check({tag, ".no_early_done"}, {31'd0, done_ok}, 32'd1);
        check({tag, ".start_stop_bits"}, {31'd0, framing_ok}, 32'd1);
        for (int i = 0; i < 9; i++) check($sformatf("%s.byte%0d", tag, i), {24'd0, dec[i]}, {24'd0, exp_f[i]});
        @(negedge clk);
        check({tag, ".idle_after_done.busy"}, {31'd0, busy}, 32'd0);
        check({tag, ".idle_after_done.done"}, {31'd0, done}, 32'd0);
        check({tag, ".idle_after_done.tx"}, {31'd0, tx}, 32'd1);
        @(negedge clk);
        if (mode == 2) begin
            check({tag, ".next_frame.busy"}, {31'd0, busy}, 32'd1);
            check({tag, ".next_frame.start_bit"}, {31'd0, tx}, 32'd0);
            start = 1'b0;
            seen = 0;
            for (int k = 0; k < 100*CPB && !seen; k++) begin
                @(negedge clk);
                if (done === 1'b1) seen = 1;
            end
            check({tag, ".next_frame.done_seen"}, {31'd0, seen}, 32'd1);
            @(negedge clk);
        end else begin
            check({tag, ".no_queued_frame"}, {31'd0, busy}, 32'd0);
        end
    endtask

    task automatic randomize_inputs();
        pc    = 8'($urandom);
        op    = 8'($urandom);
        acc   = 16'($urandom);
        mr    = 16'($urandom);
        flags = 5'($urandom);
    endtask

    initial begin
        bit ok;
        rst_n = 1'b0; start = 1'b0;
        pc = 0; op = 0; acc = 0; mr = 0; flags = 0;
        s_rst_n = 1'b0; s_start = 1'b0;
        s_pc = 8'h55; s_op = 8'h0F; s_acc = 16'h1234; s_mr = 16'h5678; s_flags = 5'h0A;

        ok = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start = ~start;
            #1;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) ok = 0;
        end
        check("reset.tx", {31'd0, tx}, 32'd1);
        check("reset.busy", {31'd0, busy}, 32'd0);
        check("reset.done", {31'd0, done}, 32'd0);
        check("reset.held_quiet", {31'd0, ok}, 32'd1);
        @(negedge clk); start = 1'b0; rst_n = 1'b1; s_rst_n = 1'b1;
        @(negedge clk);

        pc = 8'h12; op = 8'h34; acc = 16'h5678; mr = 16'h9ABC; flags = 5'h1F;
        build_frame(pc, op, acc, mr, flags, exp_f);
        check("basic.model_checksum", {24'd0, exp_f[8]}, 32'h31);
        run_frame(0, "basic");

        pc = 8'h12; op = 8'h34; acc = 16'h5678; mr = 16'h9ABC; flags = 5'h1F;
        run_frame(1, "snapshot");

        pc = 0; op = 0; acc = 0; mr = 0; flags = 0;
        run_frame(0, "zero");

        for (int r = 0; r < 3; r++) begin
            randomize_inputs();
            run_frame(0, $sformatf("rand%0d", r));
        end

        randomize_inputs();
        acc[7:0] = 8'h00;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int k = 0; k < 43*CPB; k++) @(negedge clk);
        check("midreset.tx_low_before", {31'd0, tx}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("midreset.tx_async", {31'd0, tx}, 32'd1);
        check("midreset.busy_async", {31'd0, busy}, 32'd0);
        ok = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = ~start;
            #1;
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) ok = 0;
        end
        start = 1'b0;
        rst_n = 1'b1;
        ok = ok && 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) ok = 0;
        end
        check("midreset.quiet_no_done", {31'd0, ok}, 32'd1);
        randomize_inputs();
        run_frame(0, "after_reset");

        randomize_inputs();
        run_frame(2, "held");

        build_frame(s_pc, s_op, s_acc, s_mr, s_flags, exp_s);
        @(negedge clk); s_start = 1'b1;
        @(negedge clk); s_start = 1'b0;
        for (int k = 0; k <= 20*SCPB; k++) begin
            int j, r;
            j = k / SCPB;
            r = k % SCPB;
            if (r == 0 || r == SCPB-1)
                check($sformatf("slow.bit%0d.%s", j, (r == 0) ? "first" : "last"),
                      {31'd0, s_tx}, {31'd0, line_bit(exp_s[j/10], j % 10)});
            if (k < 20*SCPB) @(negedge clk);
        end
        check("slow.busy", {31'd0, s_busy}, 32'd1);
        s_rst_n = 1'b0;
        #1;
        check("slow.reset_tx", {31'd0, s_tx}, 32'd1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
